final_project_soc_from_sw_sig_import: RTL and testbench



---
 rtl/final_project_soc_pio_pkg.sv | 12 +
 rtl/final_project_soc_req_ack_master.sv | 49 ++++
 rtl/final_project_soc_from_sw_sig_import.sv | 62 ++++++
 tb/tb_final_project_soc_from_sw_sig_import.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/final_project_soc_pio_pkg.sv
// final_project_soc_pio_pkg: register map, status bit indices and command FSM states
package final_project_soc_pio_pkg;
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_SET  = 2'd1;
   localparam logic [1:0] ADDR_CLR  = 2'd2;
   localparam logic [1:0] ADDR_CMD  = 2'd3;
   localparam int BUSY          = 0;
   localparam int DONE          = 1;
   localparam int OVF           = 2;
   localparam int CLR_FLAGS_BIT = 31;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} cmd_state_t;
endpackage

// File: rtl/final_project_soc_req_ack_master.sv
// final_project_soc_req_ack_master: four-phase req/ack master with payload latch and sticky done/overflow
module final_project_soc_req_ack_master
   import final_project_soc_pio_pkg::*;
#(
   parameter int CMD_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_launch,
   input  logic                 i_clear,
   input  logic [CMD_WIDTH-1:0] i_payload,
   input  logic                 i_ack,
   output logic                 o_req,
   output logic [CMD_WIDTH-1:0] o_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_ovf
);
   cmd_state_t r_state, w_next;
   logic r_done, r_ovf;
   logic [CMD_WIDTH-1:0] r_data;
   logic w_accept, w_finish;
   always_comb begin
      w_accept = i_launch && r_state == IDLE;
      w_finish = r_state == WAIT_LOW && !i_ack;
      w_next   = w_accept ? REQ :
                 (r_state == REQ && i_ack) ? WAIT_LOW :
                 w_finish ? IDLE : r_state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_data <= i_payload;
         // completion beats a simultaneous software clear
         r_done <= w_finish ? 1'b1 : i_clear ? 1'b0 : r_done;
         r_ovf  <= (i_launch && !w_accept) ? 1'b1 : i_clear ? 1'b0 : r_ovf;
      end
   end
   assign o_req  = r_state == REQ;
   assign o_busy = r_state != IDLE;
   assign o_data = r_data;
   assign o_done = r_done;
   assign o_ovf  = r_ovf;
endmodule

// File: rtl/final_project_soc_from_sw_sig_import.sv
// final_project_soc_from_sw_sig_import: Avalon-MM output port with set/clear aliases and command handshake
module final_project_soc_from_sw_sig_import
   import final_project_soc_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 2,
   parameter int                    CMD_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  cmd_req,
   output logic [CMD_WIDTH-1:0]  cmd_data,
   input  logic                  cmd_ack
);
   logic [DATA_WIDTH-1:0] r_out, w_wd;
   logic [31:0] r_rd, w_status, w_rd_mux;
   logic w_wr, w_cmd_wr, w_busy, w_done, w_ovf;
   always_comb begin
      w_wr     = chipselect && !write_n;
      w_cmd_wr = w_wr && address == ADDR_CMD;
      w_wd     = writedata[DATA_WIDTH-1:0];
      w_status = '0;
      w_status[BUSY] = w_busy;
      w_status[DONE] = w_done;
      w_status[OVF]  = w_ovf;
      w_rd_mux = (address == ADDR_DATA) ? 32'(r_out) :
                 (address == ADDR_CMD) ? w_status : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= RESET_VALUE;
         r_rd  <= '0;
      end else begin
         r_rd <= w_rd_mux;
         if (w_wr)
            r_out <= (address == ADDR_DATA) ? w_wd :
                     (address == ADDR_SET) ? (r_out | w_wd) :
                     (address == ADDR_CLR) ? (r_out & ~w_wd) : r_out;
      end
   end
   final_project_soc_req_ack_master #(.CMD_WIDTH(CMD_WIDTH)) u_master (
      .clk       (clk),
      .reset     (reset),
      .i_launch  (w_cmd_wr && !writedata[CLR_FLAGS_BIT]),
      .i_clear   (w_cmd_wr && writedata[CLR_FLAGS_BIT]),
      .i_payload (writedata[CMD_WIDTH-1:0]),
      .i_ack     (cmd_ack),
      .o_req     (cmd_req),
      .o_data    (cmd_data),
      .o_busy    (w_busy),
      .o_done    (w_done),
      .o_ovf     (w_ovf)
   );
   assign out_port = r_out;
   assign readdata = r_rd;
endmodule

// File: tb/tb_final_project_soc_from_sw_sig_import.sv
// tb_final_project_soc_from_sw_sig_import: directed and random stimulus checked each cycle against a behavioural model
module tb_final_project_soc_from_sw_sig_import;
   logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1, cmd_ack = 1'b0;
   logic [1:0] address = '0;
   logic [31:0] writedata = '0, readdata;
   logic [1:0] out_port;
   logic cmd_req;
   logic [7:0] cmd_data;
   int checks = 0, errors = 0;
   // model: phase 0 = no command outstanding, 1 = requesting, 2 = waiting for ack to drop
   logic [1:0] m_out;
   logic [31:0] m_rd;
   logic [7:0] m_cmd;
   int m_phase;
   logic m_done, m_ovf;
   final_project_soc_from_sw_sig_import #(.DATA_WIDTH(2), .CMD_WIDTH(8), .RESET_VALUE(2'b01)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .out_port(out_port), .cmd_req(cmd_req),
      .cmd_data(cmd_data), .cmd_ack(cmd_ack)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] m_status();
      return {29'b0, m_ovf, m_done, m_phase != 0};
   endfunction
   task automatic step();
      logic wr, launch, clr, nd, no;
      logic [1:0] nout;
      logic [31:0] nrd;
      logic [7:0] ncmd;
      int nph;
      wr = chipselect && !write_n;
      launch = wr && address == 3 && !writedata[31];
      clr = wr && address == 3 && writedata[31];
      nrd = address == 0 ? {30'b0, m_out} : address == 3 ? m_status() : 32'b0;
      nout = m_out;
      if (wr && address == 0) nout = writedata[1:0];
      if (wr && address == 1) nout = m_out | writedata[1:0];
      if (wr && address == 2) nout = m_out & ~writedata[1:0];
      nph = m_phase;
      ncmd = m_cmd;
      nd = clr ? 1'b0 : m_done;
      no = clr ? 1'b0 : m_ovf;
      if (launch && m_phase != 0) no = 1'b1;
      if (m_phase == 0 && launch) begin nph = 1; ncmd = writedata[7:0]; end
      else if (m_phase == 1 && cmd_ack) nph = 2;
      else if (m_phase == 2 && !cmd_ack) begin nph = 0; nd = 1'b1; end
      if (reset) begin
         nout = 2'b01; nrd = 0; nph = 0; ncmd = 0; nd = 0; no = 0;
      end
      @(posedge clk);
      #1;
      m_out = nout; m_rd = nrd; m_phase = nph; m_cmd = ncmd; m_done = nd; m_ovf = no;
      chk("out_port", 32'(out_port), 32'(m_out));
      chk("readdata", readdata, m_rd);
      chk("cmd_req", 32'(cmd_req), 32'(m_phase == 1));
      chk("cmd_data", 32'(cmd_data), 32'(m_cmd));
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      m_out = 2'b01; m_rd = 0; m_cmd = 0; m_phase = 0; m_done = 0; m_ovf = 0;
      idle(2);
      chk("rst_out", 32'(out_port), 32'h1);
      chk("rst_rd", readdata, 32'h0);
      chk("rst_req", 32'(cmd_req), 32'h0);
      reset = 1'b0;
      address = 3;
      idle(1);
      chk("rst_status", readdata, 32'h0);
      wr(0, 32'h3);
      chk("data_wr", 32'(out_port), 32'h3);
      wr(2, 32'h1);
      chk("clr_wr", 32'(out_port), 32'h2);
      wr(1, 32'h0);
      chk("set_wr", 32'(out_port), 32'h2);
      chk("rd_set", readdata, 32'h0);
      address = 0;
      idle(1);
      chk("rd_data", readdata, 32'h2);
      address = 2;
      idle(1);
      chk("rd_clr", readdata, 32'h0);
      wr(3, 32'hA5);
      chk("hs_req", 32'(cmd_req), 32'h1);
      chk("hs_data", 32'(cmd_data), 32'hA5);
      idle(2);
      chk("hs_busy", readdata, 32'h1);
      cmd_ack = 1'b1;
      idle(1);
      chk("hs_req_drop", 32'(cmd_req), 32'h0);
      idle(1);
      cmd_ack = 1'b0;
      idle(2);
      chk("hs_done", readdata, 32'h2);
      wr(3, 32'h8000_0000);
      wr(3, 32'h11);
      wr(3, 32'h22);
      idle(1);
      chk("ovf_data", 32'(cmd_data), 32'h11);
      chk("ovf_status", readdata, 32'h5);
      wr(3, 32'h8000_0000);
      idle(1);
      chk("ovf_clear", readdata, 32'h1);
      cmd_ack = 1'b1;
      idle(1);
      cmd_ack = 1'b0;
      idle(2);
      wr(3, 32'h33);
      reset = 1'b1;
      idle(1);
      chk("midrst_req", 32'(cmd_req), 32'h0);
      chk("midrst_data", 32'(cmd_data), 32'h0);
      reset = 1'b0;
      wr(3, 32'h44);
      idle(5);
      chk("req_hold", 32'(cmd_req), 32'h1);
      cmd_ack = 1'b1;
      idle(1);
      cmd_ack = 1'b0;
      idle(1);
      wr(3, 32'h8000_0000);
      cmd_ack = 1'b1;
      idle(5);
      chk("spur_status", readdata, 32'h0);
      wr(3, 32'h55);
      chk("fast_req", 32'(cmd_req), 32'h1);
      idle(1);
      chk("fast_pass", 32'(cmd_req), 32'h0);
      cmd_ack = 1'b0;
      idle(2);
      for (int i = 0; i < 3000; i++) begin
         reset = $urandom_range(0, 299) == 0;
         chipselect = $urandom_range(0, 2) != 0;
         write_n = $urandom_range(0, 1) == 0;
         address = 2'($urandom_range(0, 3));
         writedata = {($urandom_range(0, 3) == 0), 31'($urandom)};
         if ($urandom_range(0, 3) == 0) cmd_ack = ~cmd_ack;
         step();
      end
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
